// File: rtl/pong_round_ctrl.sv
// pong_round_ctrl
// Frame-level round sequencer for the Pong top level. It debounces the start
// and pause buttons by sampling them on the frame strobe. It runs the round
// state machine (idle, serve, play, pause, point, over) and keeps both scores.
// It gates the movers: they only animate in PLAY, and they are recentred while
// idle or serving.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_ani_stb    one-cycle frame strobe
//   i_start_btn  raw start button (asynchronous)
//   i_pause_btn  raw pause button (asynchronous)
//   i_miss_p1    ball passed player 1 -> point for P2 (one-cycle pulse)
//   i_miss_p2    ball passed player 2 -> point for P1 (one-cycle pulse)
//   o_animate    mover enable, high only in PLAY
//   o_obj_rst    recentre paddles and ball, high in IDLE and SERVE
//   o_state      current state code (0..5)
//   o_score_p1   player 1 score
//   o_score_p2   player 2 score
//   o_winner     0 none, 1 P1, 2 P2, 3 draw
module pong_round_ctrl #(
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ani_stb,
  input  logic       i_start_btn,
  input  logic       i_pause_btn,
  input  logic       i_miss_p1,
  input  logic       i_miss_p2,
  output logic       o_animate,
  output logic       o_obj_rst,
  output logic [2:0] o_state,
  output logic [3:0] o_score_p1,
  output logic [3:0] o_score_p2,
  output logic [1:0] o_winner
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);

  logic       start_meta_r, start_sync_r, start_smp_r, start_evt_r;
  logic       pause_meta_r, pause_sync_r, pause_smp_r, pause_evt_r;
  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_inc_s, cnt_s;
  logic [3:0] score_p1_r, score_p1_s;
  logic [3:0] score_p2_r, score_p2_s;
  logic [1:0] winner_r, winner_s;
  logic       animate_r, obj_rst_r;
  logic       p1_win_s, p2_win_s;

  // Button synchronizers and frame-rate edge detection (sampling only at strobes
  // is what debounces the contacts).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_smp_r  <= 1'b0;
      start_evt_r  <= 1'b0;
      pause_meta_r <= 1'b0;
      pause_sync_r <= 1'b0;
      pause_smp_r  <= 1'b0;
      pause_evt_r  <= 1'b0;
    end else begin
      start_meta_r <= i_start_btn;
      start_sync_r <= start_meta_r;
      pause_meta_r <= i_pause_btn;
      pause_sync_r <= pause_meta_r;
      if (i_ani_stb) begin
        start_smp_r <= start_sync_r;
        start_evt_r <= start_sync_r & ~start_smp_r;
        pause_smp_r <= pause_sync_r;
        pause_evt_r <= pause_sync_r & ~pause_smp_r;
      end else begin
        start_evt_r <= 1'b0;
        pause_evt_r <= 1'b0;
      end
    end
  end

  assign p1_win_s = (score_p1_r == WIN_VAL);
  assign p2_win_s = (score_p2_r == WIN_VAL);

  // Next-state, frame counter and score logic.
  always_comb begin
    state_s    = state_r;
    cnt_inc_s  = cnt_r;
    score_p1_s = score_p1_r;
    score_p2_s = score_p2_r;
    winner_s   = winner_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_evt_r) begin
          state_s    = ST_SERVE;
          score_p1_s = 4'd0;
          score_p2_s = 4'd0;
          winner_s   = 2'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_SERVE: begin
        if (cnt_r == SERVE_CNT) begin
          state_s = ST_PLAY;
        end else if (i_ani_stb) begin
          cnt_inc_s = cnt_r + 8'd1;
        end else begin
          cnt_inc_s = cnt_r;
        end
      end
      ST_PLAY: begin
        // A miss wins over a pause press arriving in the same cycle.
        if (i_miss_p1 | i_miss_p2) begin
          state_s    = ST_POINT;
          score_p1_s = score_p1_r + {3'd0, i_miss_p2};
          score_p2_s = score_p2_r + {3'd0, i_miss_p1};
        end else if (pause_evt_r) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_evt_r) begin
          state_s = ST_PLAY;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_POINT: begin
        if (cnt_r == POINT_CNT) begin
          if (p1_win_s | p2_win_s) begin
            state_s  = ST_OVER;
            winner_s = {p2_win_s, p1_win_s};
          end else begin
            state_s = ST_SERVE;
          end
        end else if (i_ani_stb) begin
          cnt_inc_s = cnt_r + 8'd1;
        end else begin
          cnt_inc_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Every state entry starts its frame count from zero.
    cnt_s = (state_s != state_r) ? 8'd0 : cnt_inc_s;
  end

  // State, counter, scores and registered mover controls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      score_p1_r <= 4'd0;
      score_p2_r <= 4'd0;
      winner_r   <= 2'd0;
      animate_r  <= 1'b0;
      obj_rst_r  <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      score_p1_r <= score_p1_s;
      score_p2_r <= score_p2_s;
      winner_r   <= winner_s;
      // Decoded from the next state so they switch on the same edge as state.
      animate_r  <= (state_s == ST_PLAY);
      obj_rst_r  <= (state_s == ST_IDLE) || (state_s == ST_SERVE);
    end
  end

  assign o_state    = state_r;
  assign o_animate  = animate_r;
  assign o_obj_rst  = obj_rst_r;
  assign o_score_p1 = score_p1_r;
  assign o_score_p2 = score_p2_r;
  assign o_winner   = winner_r;

endmodule
